// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the MEM-stage load/store unit: RV32I
//            load/store funct3 codes, access FSM states, byte-enable type and
//            store lane helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // RV32I load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // RV32I store funct3 encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [3:0] wstrb_t;

    // Byte enables for a store of the given size (funct3[1:0]) at byte offset
    function automatic wstrb_t store_strb(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   return wstrb_t'(4'b0001 << offset);
            2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane the size could land in
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module   : load_extender
// Purpose  : Selects the addressed byte/halfword lane of a RAM read word and
//            sign- or zero-extends it to 32 bits according to the load funct3.
// Revision : 1.0 - initial release
// ============================================================================
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by extension chosen by the load type
    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      data = {{24{byte_lane[7]}}, byte_lane};
            LBU:     data = {24'h000000, byte_lane};
            LH:      data = {{16{half_lane[15]}}, half_lane};
            LHU:     data = {16'h0000, half_lane};
            default: data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store unit. Issues one req/ack transaction per
//            memory instruction, stalls the pipeline while it is in flight,
//            and returns the aligned, extended load result to MEM/WB.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int MAX_WAIT   = 255
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [2:0]            in_funct3,
    input  logic [31:0]           in_address,
    input  logic [31:0]           in_store_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output wstrb_t                mem_wstrb,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           ram_data,
    output logic                  stall,
    output logic                  fault
);

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic [31:0] ext_data;
    logic        mem_op;
    logic        bad_funct3;
    logic        misaligned;
    logic        accept;
    logic        reject;
    logic        timeout;
    logic        unused_addr_bits;

    // Upper byte-address bits lie beyond the data RAM and are ignored
    assign unused_addr_bits = ^in_address[31:ADDR_WIDTH+2];

    load_extender u_load_extender (
        .rdata  (mem_rdata),
        .offset (ld_offset),
        .funct3 (ld_funct3),
        .data   (ext_data)
    );

    // Decode the EX/MEM operation into accept (issue) or reject (fault)
    always_comb begin
        mem_op = in_valid && (in_mem_read || in_mem_write);
        if (in_mem_write)
            bad_funct3 = in_funct3[2] || (in_funct3[1:0] == 2'b11);
        else
            bad_funct3 = (in_funct3 == 3'b011) || (in_funct3[2:1] == 2'b11);
        case (in_funct3[1:0])
            2'b01:   misaligned = in_address[0];
            2'b10:   misaligned = |in_address[1:0];
            default: misaligned = 1'b0;
        endcase
        reject = mem_op && ((in_mem_read && in_mem_write) || bad_funct3 || misaligned);
        accept = mem_op && !reject;
    end

    // Access FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state plus stall/fault; both are held low during reset
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        fault      = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    state_next = BUSY;
                end else if (reject) begin
                    fault = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    state_next = DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    fault      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!reset_n) begin
            stall = 1'b0;
            fault = 1'b0;
        end
    end

    // Request fields, wait counter and the load result register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            ram_data  <= '0;
            wait_cnt  <= '0;
            ld_funct3 <= '0;
            ld_offset <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (accept) begin
                        mem_req   <= 1'b1;
                        mem_we    <= in_mem_write;
                        mem_addr  <= in_address[ADDR_WIDTH+1:2];
                        mem_wdata <= in_mem_write ? store_lanes(in_funct3[1:0], in_store_data) : 32'h0;
                        mem_wstrb <= in_mem_write ? store_strb(in_funct3[1:0], in_address[1:0]) : 4'h0;
                        ld_funct3 <= in_funct3;
                        ld_offset <= in_address[1:0];
                    end else if (reject) begin
                        ram_data <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            ram_data <= ext_data;
                    end else if (timeout) begin
                        mem_req  <= 1'b0;
                        ram_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit (MAX_WAIT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_mem_read = 1'b0;
    logic        in_mem_write = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_address = 32'h0;
    logic [31:0] in_store_data = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] ram_data;
    logic        stall;
    logic        fault;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_unit #(.ADDR_WIDTH(17), .MAX_WAIT(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_funct3     (in_funct3),
        .in_address    (in_address),
        .in_store_data (in_store_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .ram_data      (ram_data),
        .stall         (stall),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Present one EX/MEM instruction (stimulus only)
    task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sdata);
        in_valid      = 1'b1;
        in_mem_read   = rd;
        in_mem_write  = wr;
        in_funct3     = f3;
        in_address    = addr;
        in_store_data = sdata;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_op(1'b1, 1'b0, LW, 32'h10, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_cmp++; if ({mem_req, mem_we, mem_wstrb, fault} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl: got req=%0b we=%0b wstrb=%b fault=%0b want all 0", mem_req, mem_we, mem_wstrb, fault); end
        n_cmp++; if (mem_addr !== 17'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_fields: got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
        n_cmp++; if (ram_data !== 32'h0) begin n_fail++; $display("FAIL reset_ram_data: got %h want 0", ram_data); end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        drive_op(1'b1, 1'b0, LW, 32'h0000_0010, 32'h0);
        #1;
        n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_idle: got stall=%0b req=%0b want 1/0", stall, mem_req); end
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd4) begin n_fail++; $display("FAIL lw_busy_req: got req=%0b we=%0b addr=%h want 1/0/4", mem_req, mem_we, mem_addr); end
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_busy_stall: got %0b want 1", stall); end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL lw_done_ctrl: got stall=%0b req=%0b want 0/0", stall, mem_req); end
        n_cmp++; if (ram_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_done_data: got %h want deadbeef", ram_data); end
        @(negedge clk);
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s   [6] = '{LB, LBU, LH, LHU, LBU, LH};
        logic [31:0] addrs [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h0105, 32'h1000};
        logic [31:0] rds   [6] = '{32'h8011_2233, 32'h8011_2233, 32'h8011_2233, 32'h8011_2233, 32'h8011_2233, 32'h1234_8123};
        logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_8011, 32'h0000_0022, 32'hFFFF_8123};
        int          waits [6] = '{0, 1, 0, 2, 0, 1};
        for (int i = 0; i < 6; i++) begin
            drive_op(1'b1, 1'b0, f3s[i], addrs[i], 32'h0);
            @(negedge clk);
            in_valid = 1'b0;
            for (int w = 0; w < waits[i]; w++) begin
                #1;
                n_cmp++; if (mem_req !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL ld%0d_wait%0d: got req=%0b stall=%0b want 1/1", i, w, mem_req, stall); end
                @(negedge clk);
            end
            mem_ack = 1'b1; mem_rdata = rds[i];
            #1;
            n_cmp++; if (mem_addr !== 17'(addrs[i] >> 2)) begin n_fail++; $display("FAIL ld%0d_addr: got %h want %h", i, mem_addr, 17'(addrs[i] >> 2)); end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            n_cmp++; if (ram_data !== exps[i] || stall !== 1'b0) begin n_fail++; $display("FAIL ld%0d_data: got %h stall=%0b want %h stall=0", i, ram_data, stall, exps[i]); end
            @(negedge clk);
        end
    endtask

    // Runs after test_load_extend, whose last result was 0xFFFF8123
    task automatic test_store();
        logic [2:0]  f3s   [3] = '{SB, SH, SW};
        logic [31:0] addrs [3] = '{32'h0101, 32'h0202, 32'h0308};
        logic [31:0] sds   [3] = '{32'h0000_00AB, 32'h1234_CDEF, 32'h0102_0304};
        logic [31:0] wds   [3] = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'h0102_0304};
        logic [3:0]  strbs [3] = '{4'b0010, 4'b1100, 4'b1111};
        logic [16:0] mads  [3] = '{17'h40, 17'h80, 17'hC2};
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b0, 1'b1, f3s[i], addrs[i], sds[i]);
            #1;
            n_cmp++; if (stall !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL st%0d_idle: got stall=%0b fault=%0b want 1/0", i, stall, fault); end
            @(negedge clk);
            in_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
            #1;
            n_cmp++; if ({mem_req, mem_we, mem_wstrb} !== {1'b1, 1'b1, strbs[i]}) begin n_fail++; $display("FAIL st%0d_ctrl: got req=%0b we=%0b wstrb=%b want 1/1/%b", i, mem_req, mem_we, mem_wstrb, strbs[i]); end
            n_cmp++; if (mem_wdata !== wds[i] || mem_addr !== mads[i]) begin n_fail++; $display("FAIL st%0d_fields: got wdata=%h addr=%h want %h/%h", i, mem_wdata, mem_addr, wds[i], mads[i]); end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            n_cmp++; if (ram_data !== 32'hFFFF_8123) begin n_fail++; $display("FAIL st%0d_ram_data: got %h want ffff8123", i, ram_data); end
            @(negedge clk);
        end
    endtask

    task automatic test_fault();
        logic        rds   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        wrs   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0]  f3s   [6] = '{LW, LH, 3'b011, 3'b110, LW, SW};
        logic [31:0] addrs [6] = '{32'h1002, 32'h1001, 32'h1000, 32'h1000, 32'h1000, 32'h1001};
        for (int i = 0; i < 6; i++) begin
            drive_op(rds[i], wrs[i], f3s[i], addrs[i], 32'hFFFF_FFFF);
            #1;
            n_cmp++; if (fault !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL flt%0d_idle: got fault=%0b stall=%0b want 1/0", i, fault, stall); end
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_cmp++; if (mem_req !== 1'b0 || fault !== 1'b0 || ram_data !== 32'h0) begin n_fail++; $display("FAIL flt%0d_after: got req=%0b fault=%0b ram_data=%h want 0/0/0", i, mem_req, fault, ram_data); end
            @(negedge clk);
        end
        drive_op(1'b1, 1'b0, 3'b011, 32'h1002, 32'h0);
        in_valid = 1'b0;
        #1;
        n_cmp++; if (fault !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flt_not_valid: got fault=%0b stall=%0b want 0/0", fault, stall); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        drive_op(1'b1, 1'b0, LW, 32'h20, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++; if (ram_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL to_preload: got %h want cafef00d", ram_data); end
        @(negedge clk);
        drive_op(1'b1, 1'b0, LW, 32'h24, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (mem_req === 1'b1) req_cycles++;
            n_cmp++; if (fault !== (c == 3)) begin n_fail++; $display("FAIL to_fault_c%0d: got %0b want %0b", c, fault, (c == 3)); end
            @(negedge clk);
        end
        n_cmp++; if (req_cycles != 4) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 4", req_cycles); end
        #1;
        n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL to_done_ctrl: got req=%0b stall=%0b fault=%0b want 0/0/0", mem_req, stall, fault); end
        n_cmp++; if (ram_data !== 32'h0) begin n_fail++; $display("FAIL to_done_data: got %h want 0", ram_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_busy();
        drive_op(1'b1, 1'b0, LW, 32'h30, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; reset_n = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL rb_in_reset: got stall=%0b req=%0b want 0/1", stall, mem_req); end
        @(negedge clk);
        reset_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rb_after_reset: got req=%0b stall=%0b want 0/0", mem_req, stall); end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++; if (ram_data !== 32'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rb_late_ack: got ram_data=%h req=%0b want 0/0", ram_data, mem_req); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive_op(1'b1, 1'b0, LW, 32'h40, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        drive_op(1'b1, 1'b0, LHU, 32'h46, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        #1;
        n_cmp++; if (stall !== 1'b0 || mem_req !== 1'b0 || ram_data !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_done: got stall=%0b req=%0b ram_data=%h want 0/0/11111111", stall, mem_req, ram_data); end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b1 || mem_req !== 1'b0 || ram_data !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_idle: got stall=%0b req=%0b ram_data=%h want 1/0/11111111", stall, mem_req, ram_data); end
        @(negedge clk);
        in_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hABCD_0000;
        #1;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 17'h11) begin n_fail++; $display("FAIL b2b_busy: got req=%0b addr=%h want 1/11", mem_req, mem_addr); end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++; if (ram_data !== 32'h0000_ABCD) begin n_fail++; $display("FAIL b2b_data: got %h want 0000abcd", ram_data); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_fault();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
